// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths, PC step and FIFO entry type for the fetch stage
package inst_fetch_unit_pkg;
  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_skid_fifo: 2-entry {pc,inst} FIFO; head is a register so it holds when drained
module fetch_skid_fifo
  import inst_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t tail;
  logic wr_tail;
  assign wr_tail = pop ? count == 2'd2 : count != 2'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop && count == 2'd2) head <= tail;
      if (push && wr_tail) tail <= din;
      if (push && !wr_tail) head <= din;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner feeding a 1-cycle-latency instruction memory, with
// credit-based issue into a 2-entry output FIFO, redirect flush and sticky halt.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted
);
  logic [31:0] pc_q, req_pc_q, target;
  logic inflight_q, issue, deq, push;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_entry_t head, din;
  always_comb begin
    target    = {redirect_pc[31:2], 2'b00};
    imem_addr = rst ? RESET_PC : redirect_valid ? target : pc_q;
    out_valid = count != 2'd0 && !redirect_valid;
    deq       = out_valid && out_ready;
    // a redirect empties the FIFO and drops the in-flight read, freeing all credit
    occ       = redirect_valid ? 3'd0 : {1'b0, count} + {2'b0, inflight_q} - {2'b0, deq};
    issue     = !halted && !halt && occ < 3'(DEPTH);
    push      = inflight_q && !redirect_valid;
    din       = '{pc: req_pc_q, inst: imem_inst};
    out_pc    = head.pc;
    out_inst  = head.inst;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      halted     <= 1'b0;
    end else begin
      halted     <= halted | halt;
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= imem_addr + PC_INC;
        req_pc_q <= imem_addr;
      end else if (redirect_valid) begin
        pc_q <= target;
      end
    end
  fetch_skid_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(deq),
    .flush(redirect_valid),
    .din(din),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and random stimulus; delivered instructions are
// checked against a stream model (sequential PCs from the last redirect/reset).
module tb_inst_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  logic clk = 1'b0, rst = 1'b1;
  logic redirect_valid = 1'b0, halt = 1'b0, out_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_inst, out_pc, out_inst;
  logic out_valid, halted;
  logic [31:0] imem_addr2, imem_inst2, out_pc2, out_inst2;
  logic out_valid2, halted2;
  int checks = 0, errors = 0, delivered = 0;
  logic [31:0] exp1, exp2, last1, a;
  logic saw_valid, found;

  always #5 clk = ~clk;
  always @(posedge clk) imem_inst <= imem_addr ^ K;
  always @(posedge clk) imem_inst2 <= imem_addr2 ^ K;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .halted(halted)
  );
  inst_fetch_unit #(.RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_inst(imem_inst2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2),
    .out_inst(out_inst2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb();
    if (rst) begin
      exp1 = 32'h0;
      exp2 = WRAP_PC;
    end else begin
      saw_valid = saw_valid | out_valid;
      if (redirect_valid) begin
        chk("redirect_no_handshake", {31'b0, out_valid}, 32'd0);
        exp1 = {redirect_pc[31:2], 2'b00};
      end else if (out_valid && out_ready) begin
        chk("stream_pc", out_pc, exp1);
        chk("stream_inst", out_inst, exp1 ^ K);
        last1 = exp1;
        exp1 += 32'd4;
        delivered++;
      end
      if (out_valid2) begin
        chk("wrap_stream_pc", out_pc2, exp2);
        chk("wrap_stream_inst", out_inst2, exp2 ^ K);
        exp2 += 32'd4;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb();
    @(posedge clk);
    #1;
  endtask

  initial begin
    saw_valid = 1'b0;
    last1 = '0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_imem_addr_wrap", imem_addr2, WRAP_PC);
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("first_valid", {31'b0, out_valid}, {31'b0, k >= 2});
      if (k >= 2) chk("first_pc", out_pc, 32'(4 * (k - 2)));
      if (k == 2) chk("wrap_pc0", out_pc2, WRAP_PC);
      if (k == 3) chk("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
      if (k == 4) chk("wrap_pc2", out_pc2, 32'h0000_0000);
      step();
    end
    out_ready = 1'b0;
    a = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 1) a = imem_addr;
      if (k >= 2) begin
        chk("stall_addr_hold", imem_addr, a);
        chk("stall_addr_next", imem_addr, out_pc + 32'd8);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("redir_valid_low", {31'b0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_gap", {31'b0, out_valid}, 32'd0);
    step();
    #1;
    chk("redir_first_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_first_pc", out_pc, 32'h0000_0100);
    step();
    #1;
    chk("redir_second_pc", out_pc, 32'h0000_0104);
    step();
    for (int k = 0; k < 3; k++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    delivered = 0;
    for (int k = 0; k < 300; k++) begin
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc = $urandom & 32'h0000_0FFF;
      step();
    end
    chk("random_progress", {31'b0, delivered > 50}, 32'd1);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0010;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (imem_addr == 32'h0000_0020) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("halt_reach_0x20", {31'b0, found}, 32'd1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    #1;
    chk("halted_set", {31'b0, halted}, 32'd1);
    chk("halt_pc_hold", imem_addr, 32'h0000_0020);
    for (int k = 0; k < 4; k++) step();
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      redirect_valid = k == 1;
      redirect_pc = 32'h0000_0040;
      step();
    end
    redirect_valid = 1'b0;
    chk("halt_no_fetch", {31'b0, saw_valid}, 32'd0);
    chk("halt_last_pc", last1, 32'h0000_001C);
    chk("halted_sticky", {31'b0, halted}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_valid_wrap", {31'b0, out_valid2}, 32'd0);
    chk("midrst_halted", {31'b0, halted}, 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("restart_valid", {31'b0, out_valid}, {31'b0, k >= 2});
      if (k == 2) begin
        chk("restart_pc", out_pc, 32'd0);
        chk("restart_pc_wrap", out_pc2, WRAP_PC);
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch stage directly upstream of SynInstMem. Owns the PC, drives the memory address every cycle, and absorbs the memory's one-cycle read latency. Buffers returned instructions in a 2-entry FIFO so decode can apply a valid/ready handshake. Handles branch/jump redirects, which flush in-flight fetches, and a sticky halt from the syscall path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first address fetched.
DEPTH, 2, output FIFO entries; fixed at 2, legal value 2 only.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
imem_addr  out  32  byte address to SynInstMem; combinational.
imem_inst  in  32  SynInstMem data; corresponds to imem_addr of the previous cycle.
redirect_valid  in  1  taken branch/jump this cycle.
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
halt  in  1  stop fetching; sticky until rst.
out_valid  out  1  head FIFO entry valid to decode.
out_ready  in  1  decode accepts head this cycle.
out_pc  out  32  PC of head instruction.
out_inst  out  32  head instruction word.
halted  out  1  halt latched.

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, inflight_q=0, FIFO count=0 and storage zeroed, halted=0, out_valid=0, out_pc=0, out_inst=0. While rst is high, imem_addr=RESET_PC.
- Address mux: imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q. Always driven; a memory read is harmless.
- deq = out_valid & out_ready.
- Issue condition: issue = !halted & !halt & (count + inflight_q - deq < DEPTH).
  - On issue: pc_q <= imem_addr+4 (wraps modulo 2^32), req_pc_q <= imem_addr, inflight_q <= 1.
  - No issue: inflight_q <= 0; pc_q holds, except on redirect, where pc_q <= aligned redirect_pc.
- Response: when inflight_q=1 and redirect_valid=0, push {req_pc_q, imem_inst} into the FIFO that cycle. Credit check guarantees no overflow.
- Latency: address issued in cycle N, response pushed at edge N+1, out_valid=1 in cycle N+2. Sustained throughput 1 instr/cycle with out_ready held high.
- Redirect cycle:
  - FIFO count <= 0 and the in-flight response is dropped.
  - out_valid forced 0 combinationally, so a handshake cannot occur.
  - The target is issued in the same cycle (subject to halt) and appears 2 cycles later.
- Simultaneous push and deq: count unchanged, head advances, tail written.
- FIFO empty: out_valid=0; out_pc/out_inst hold the last head value (don't-care for decode).
- Halt:
  - halt=1 blocks issue in the same cycle; halted <= 1 at that edge.
  - Already-issued responses and FIFO contents drain normally.
  - Redirect while halted flushes but never issues.
  - halt and redirect in the same cycle: flush and no issue.
- Reset mid-operation: all state returns to reset values immediately; responses from pre-reset addresses are never pushed.
- No X on outputs after reset, even if imem_inst is X while inflight_q=0.

Decomposition:
- Core.vh holds `RESET_PC default, `INST_WIDTH (32), `ADDR_WIDTH (32), and `PC_INC (4).
- One sub-module, fetch_skid_fifo: 2-entry, 64-bit {pc,inst} FIFO with push, pop, flush, count, head outputs, and the same async active-high reset.
- PC/issue/halt logic stays in inst_fetch_unit.

Test Plan:
- Reset release, out_ready=1, memory preloaded with inst=addr^32'hA5A5_0000 -> out_valid first high 2 cycles after release; out_pc sequence 0,4,8,C one per cycle with matching out_inst.
- out_ready=0 for 5 cycles from steady state -> FIFO fills to 2, issue stops, imem_addr stalls on next PC. Release -> PCs resume with no loss or duplicates.
- redirect_valid=1, redirect_pc=32'h0000_0102 while FIFO holds 2 entries -> out_valid=0 that cycle; stale entries gone; next out_pc=0x100, then 0x104.
- Redirect in the same cycle as deq and push -> no handshake counted; only 0x100-stream instructions are delivered afterwards.
- halt pulse at PC=0x20 with out_ready=1 -> halted=1 next cycle; already-issued instructions drain; no further out_valid; a later redirect produces no fetch.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst mid-stream -> out_valid=0 immediately; after release, restart at RESET_PC.
